npu_infer_sched: RTL
====================

NPU_INFER_SCHED -- requirements
Module: npu_infer_sched

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the inference-memory address width.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1, the first slot address of a batch.
REQ-003 The block SHALL have parameter NUM_SLOTS, default 10, the results per batch (BASE_ADDR+NUM_SLOTS-1 <= 2^ADDR_WIDTH-1).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum cycles spent waiting for sort_done.
REQ-005 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-006 The block SHALL have ports:
  clk  in  1  clock
  reset  in  1  sync active-high reset
  npu_valid  in  1  NPU result strobe
  npu_class  in  2  NPU inference class
  npu_data  in  64  classified payload
  npu_enable  out  1  NPU may produce results
  mem_we  out  1  memory write enable
  mem_waddr  out  ADDR_WIDTH  write address
  mem_wdata  out  66  {npu_class,npu_data}
  mem_raddr  out  ADDR_WIDTH  read address, 1-cycle read latency
  mem_rdata  in  66  read data
  out_valid  out  1  drained entry valid
  out_ready  in  1  consumer accepts entry
  out_data  out  66  drained entry
  out_addr  out  8  zero-extended slot address of out_data
  sort_done  in  1  downstream sort finished (pulse)
  sort_timeout  out  1  one-cycle pulse on timeout exit
  drop_cnt  out  16  saturating count of discarded results
  batch_cnt  out  16  wrapping count of completed batches

Function
REQ-007 The FSM SHALL have states FILL, RD_ADDR, RD_WAIT, OUT, WAIT_SORT.
REQ-008 npu_enable SHALL be 1 exactly when state is FILL, decoded from the state register.
REQ-009 In FILL, npu_valid SHALL assert mem_we in the same cycle, with mem_waddr=wr_ptr and mem_wdata={npu_class,npu_data}; wr_ptr increments.
REQ-010 A write at wr_ptr=BASE_ADDR+NUM_SLOTS-1 SHALL move to RD_ADDR with rd_ptr=BASE_ADDR.
REQ-011 npu_valid in any state other than FILL SHALL NOT write and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-012 mem_raddr SHALL equal rd_ptr at all times; mem_we SHALL be 0 outside FILL.
REQ-013 RD_ADDR SHALL go to RD_WAIT unconditionally; RD_WAIT SHALL load out_data<=mem_rdata and out_addr<=rd_ptr, then go to OUT.
REQ-014 out_valid SHALL be registered and 1 exactly in OUT; out_data and out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 In OUT, out_ready=1 SHALL complete the transfer: if rd_ptr is the last slot, go to WAIT_SORT; else increment rd_ptr and go to RD_ADDR.
REQ-016 Drain throughput SHALL be one entry per 3 cycles at most; first out_valid SHALL appear 2 cycles after entering RD_ADDR.
REQ-017 On entering WAIT_SORT, timer SHALL clear; each WAIT_SORT cycle increments it.
REQ-018 In WAIT_SORT, sort_done=1 SHALL go to FILL, wr_ptr=BASE_ADDR, batch_cnt+1 (wrapping).
REQ-019 In WAIT_SORT, timer=TIMEOUT_CYCLES-1 without sort_done SHALL go to FILL as in REQ-018 and pulse sort_timeout for one cycle.
REQ-020 sort_done coincident with timeout SHALL count as sort_done; no sort_timeout pulse.
REQ-021 sort_done outside WAIT_SORT SHALL be ignored.

Reset
REQ-022 Reset SHALL set state=FILL, wr_ptr=rd_ptr=BASE_ADDR, timer=0, out_valid=0, out_data=0, out_addr=0, sort_timeout=0, drop_cnt=0, batch_cnt=0; reset mid-batch SHALL abandon partial content without any write.

Structure
REQ-023 Package npu_sched_pkg SHALL hold the state encoding, PAYLOAD_WIDTH=66, and the parameter defaults.
REQ-024 Saturating drop_cnt SHALL be a sub-module npu_sat_counter (width parameter, inc, clear, value).

Verification
REQ-025 After reset, 10 npu_valid pulses with class=i[1:0], data=i -> writes to addresses 1..10; npu_enable falls the cycle after the 10th write.
REQ-026 With out_ready=1 and mem modelled -> 10 transfers, out_addr 1..10, out_data matching, out_valid at 2 cycles after RD_ADDR entry.
REQ-027 out_ready held 0 for 5 cycles in OUT -> out_data/out_addr unchanged; transfer completes on release.
REQ-028 npu_valid during drain and WAIT_SORT for 70000 cycles -> drop_cnt=16'hFFFF, no mem_we.
REQ-029 No sort_done, TIMEOUT_CYCLES=8 -> sort_timeout one pulse after 8 WAIT_SORT cycles, batch_cnt=1, npu_enable=1; sort_done on same cycle -> no pulse.
REQ-030 Reset asserted after 4 writes -> wr_ptr=1 and all counters 0; the next batch writes starting at address 1.

Source files
------------

// File: rtl/npu_infer_sched_pkg.sv
// Shared definitions for the NPU inference scheduler: scheduler states,
// payload width and the default parameter values.
package npu_sched_pkg;

   localparam int PAYLOAD_WIDTH      = 66;
   localparam int DEF_ADDR_WIDTH     = 4;
   localparam int DEF_BASE_ADDR      = 1;
   localparam int DEF_NUM_SLOTS      = 10;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      FILL,
      RD_ADDR,
      RD_WAIT,
      OUT,
      WAIT_SORT
   } state_e;

endpackage

// File: rtl/npu_infer_sched_if.sv
// Bundle of NPU, memory, drain and sort signals around the scheduler.
// The slave view belongs to the scheduler; the master view belongs to its environment.
interface npu_infer_sched_if
   import npu_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                     npu_valid;
   logic [1:0]               npu_class;
   logic [63:0]              npu_data;
   logic                     npu_enable;
   logic                     mem_we;
   logic [ADDR_WIDTH-1:0]    mem_waddr;
   logic [PAYLOAD_WIDTH-1:0] mem_wdata;
   logic [ADDR_WIDTH-1:0]    mem_raddr;
   logic [PAYLOAD_WIDTH-1:0] mem_rdata;
   logic                     out_valid;
   logic                     out_ready;
   logic [PAYLOAD_WIDTH-1:0] out_data;
   logic [7:0]               out_addr;
   logic                     sort_done;
   logic                     sort_timeout;
   logic [15:0]              drop_cnt;
   logic [15:0]              batch_cnt;

   modport slave (
      input  npu_valid, npu_class, npu_data, mem_rdata, out_ready, sort_done,
      output npu_enable, mem_we, mem_waddr, mem_wdata, mem_raddr,
             out_valid, out_data, out_addr, sort_timeout, drop_cnt, batch_cnt
   );

   modport master (
      output npu_valid, npu_class, npu_data, mem_rdata, out_ready, sort_done,
      input  npu_enable, mem_we, mem_waddr, mem_wdata, mem_raddr,
             out_valid, out_data, out_addr, sort_timeout, drop_cnt, batch_cnt
   );

endinterface

// File: rtl/npu_infer_sched_sat_counter.sv
// Counter that stops at its all-ones value instead of wrapping.
module npu_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;

   // Clear wins over increment so a reset cycle never counts anything.
   always_ff @(posedge clk) begin
      if (clear) begin
         value_q <= '0;
      end else if (inc && (value_q != '1)) begin
         value_q <= value_q + WIDTH'(1);
      end
   end

   assign value = value_q;

endmodule

// File: rtl/npu_infer_sched.sv
// Collects a batch of NPU results into memory, drains them one by one to a
// consumer, then waits (bounded) for the downstream sort before refilling.
module npu_infer_sched
   import npu_sched_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int BASE_ADDR      = DEF_BASE_ADDR,
   parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic              clk,
   input logic              reset,
   npu_infer_sched_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] FIRST_SLOT = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_SLOT  = ADDR_WIDTH'(BASE_ADDR + NUM_SLOTS - 1);
   localparam int                    TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0]    rdPtr_q, rdPtr_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic                     outValid_q;
   logic [PAYLOAD_WIDTH-1:0] outData_q, outData_d;
   logic [7:0]               outAddr_q, outAddr_d;
   logic                     sortTimeout_q, sortTimeout_d;
   logic [15:0]              batchCnt_q, batchCnt_d;
   logic [15:0]              dropCnt;
   logic                     inFill;

   assign inFill = (state_q == FILL);

   // Next-state logic: fill -> per-entry read/present loop -> bounded sort wait.
   always_comb begin
      state_d       = state_q;
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      timer_d       = timer_q;
      outData_d     = outData_q;
      outAddr_d     = outAddr_q;
      sortTimeout_d = 1'b0;
      batchCnt_d    = batchCnt_q;
      case (state_q)
         FILL: begin
            if (bus.npu_valid) begin
               wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
               if (wrPtr_q == LAST_SLOT) begin
                  state_d = RD_ADDR;
                  rdPtr_d = FIRST_SLOT;
               end
            end
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            outData_d = bus.mem_rdata;
            outAddr_d = 8'(rdPtr_q);
            state_d   = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               if (rdPtr_q == LAST_SLOT) begin
                  state_d = WAIT_SORT;
                  timer_d = '0;
               end else begin
                  rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
                  state_d = RD_ADDR;
               end
            end
         end
         WAIT_SORT: begin
            timer_d = timer_q + TW'(1);
            // A sort_done landing on the last timer cycle counts as a normal finish.
            if (bus.sort_done || (timer_q == TIMER_LAST)) begin
               state_d       = FILL;
               wrPtr_d       = FIRST_SLOT;
               batchCnt_d    = batchCnt_q + 16'd1;
               sortTimeout_d = !bus.sort_done;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and datapath registers; reset abandons any partially filled batch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         wrPtr_q       <= FIRST_SLOT;
         rdPtr_q       <= FIRST_SLOT;
         timer_q       <= '0;
         outValid_q    <= 1'b0;
         outData_q     <= '0;
         outAddr_q     <= '0;
         sortTimeout_q <= 1'b0;
         batchCnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         timer_q       <= timer_d;
         outValid_q    <= (state_d == OUT);
         outData_q     <= outData_d;
         outAddr_q     <= outAddr_d;
         sortTimeout_q <= sortTimeout_d;
         batchCnt_q    <= batchCnt_d;
      end
   end

   npu_sat_counter #(
      .WIDTH (16)
   ) u_dropCounter (
      .clk   (clk),
      .inc   (bus.npu_valid && !inFill),
      .clear (reset),
      .value (dropCnt)
   );

   assign bus.npu_enable   = inFill;
   assign bus.mem_we       = inFill && bus.npu_valid && !reset;
   assign bus.mem_waddr    = wrPtr_q;
   assign bus.mem_wdata    = {bus.npu_class, bus.npu_data};
   assign bus.mem_raddr    = rdPtr_q;
   assign bus.out_valid    = outValid_q;
   assign bus.out_data     = outData_q;
   assign bus.out_addr     = outAddr_q;
   assign bus.sort_timeout = sortTimeout_q;
   assign bus.drop_cnt     = dropCnt;
   assign bus.batch_cnt    = batchCnt_q;

endmodule
